// File: rtl/mod_enc_round_ctrl.sv
// AES encryption round sequencer: steps SB -> SR -> MC -> ARK per round, skipping MC in the last round.
// Latency: 4*NR cycles from the start-sampling edge to the done pulse when the key is always ready.
// Backpressure: key_rdy=0 in INIT or ARK holds state and round, adding one cycle per stalled cycle.
module mod_enc_round_ctrl #(
  parameter int NR = 14
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_rdy,
  output logic       sb_en,
  output logic       sr_en,
  output logic       mc_en,
  output logic       ark_en,
  output logic [1:0] ark_src,
  output logic [3:0] round_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] NR_L = 4'(NR);

  localparam logic [1:0] SRC_PT = 2'd0;
  localparam logic [1:0] SRC_MC = 2'd1;
  localparam logic [1:0] SRC_SR = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SB,
    S_SR,
    S_MC,
    S_ARK,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] round;
  logic [3:0] round_nxt;
  logic [1:0] src_nxt;

  // Registered decodes of the state being entered; ark_en only gates the key-wait window with key_rdy.
  logic       ark_win;

  // Next-state and next-round selection; the round counter only advances out of a non-final ARK.
  always_comb begin
    state_nxt = state;
    round_nxt = round;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_INIT;
          round_nxt = 4'd0;
        end
      end
      S_INIT: begin
        if (key_rdy) begin
          state_nxt = S_SB;
          round_nxt = 4'd1;
        end
      end
      S_SB:   state_nxt = S_SR;
      S_SR:   state_nxt = (round < NR_L) ? S_MC : S_ARK;
      S_MC:   state_nxt = S_ARK;
      S_ARK: begin
        if (key_rdy) begin
          if (round < NR_L) begin
            state_nxt = S_SB;
            round_nxt = round + 4'd1;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        round_nxt = 4'd0;
      end
      default: begin
        state_nxt = S_IDLE;
        round_nxt = 4'd0;
      end
    endcase
  end

  // addRoundKey source for the state being entered: plaintext in INIT, MC output normally, SR output in the final round.
  always_comb begin
    src_nxt = SRC_PT;
    if (state_nxt == S_ARK) begin
      src_nxt = (round_nxt < NR_L) ? SRC_MC : SRC_SR;
    end
  end

  // State, round and Moore output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state     <= S_IDLE;
      round     <= 4'd0;
      sb_en     <= 1'b0;
      sr_en     <= 1'b0;
      mc_en     <= 1'b0;
      ark_win   <= 1'b0;
      ark_src   <= SRC_PT;
      round_idx <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      round     <= round_nxt;
      sb_en     <= (state_nxt == S_SB);
      sr_en     <= (state_nxt == S_SR);
      mc_en     <= (state_nxt == S_MC);
      ark_win   <= (state_nxt == S_INIT) || (state_nxt == S_ARK);
      ark_src   <= src_nxt;
      round_idx <= (state_nxt == S_IDLE) ? 4'd0 : round_nxt;
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done      <= (state_nxt == S_DONE);
    end
  end

  // The key bus handshake is the only path from an input straight to an output.
  assign ark_en = ark_win & key_rdy;

endmodule

// File: tb/tb_mod_enc_round_ctrl.sv
module tb_mod_enc_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       key_rdy = 1'b1;
  logic       sb_en, sr_en, mc_en, ark_en, busy, done;
  logic [1:0] ark_src;
  logic [3:0] round_idx;

  logic       start2 = 1'b0;
  logic       key_rdy2 = 1'b1;
  logic       sb_en2, sr_en2, mc_en2, ark_en2, busy2, done2;
  logic [1:0] ark_src2;
  logic [3:0] round_idx2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int t_start;
    int lat;
    int n_sb;
    int n_sr;
    int n_mc;
    int n_ark;
  } exp_t;

  exp_t exp_q[$];
  int   exp2_q[$];

  mod_enc_round_ctrl #(.NR(14)) dut (
    .clk(clk), .resetn(rst), .start(start), .key_rdy(key_rdy),
    .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en), .ark_en(ark_en),
    .ark_src(ark_src), .round_idx(round_idx), .busy(busy), .done(done)
  );

  mod_enc_round_ctrl #(.NR(10)) dut10 (
    .clk(clk), .resetn(rst), .start(start2), .key_rdy(key_rdy2),
    .sb_en(sb_en2), .sr_en(sr_en2), .mc_en(mc_en2), .ark_en(ark_en2),
    .ark_src(ark_src2), .round_idx(round_idx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int outs1();
    return int'({sb_en, sr_en, mc_en, ark_en, ark_src, round_idx, busy, done});
  endfunction

  // Monitor for the NR=14 instance: per-cycle invariants plus scoreboard pop on done.
  int  n_sb = 0, n_sr = 0, n_mc = 0, n_ark = 0;
  bit  fin_pending = 0;
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", outs1(), 0);
      n_sb = 0; n_sr = 0; n_mc = 0; n_ark = 0;
      fin_pending = 0;
    end else begin
      chk("one_hot_enables", int'($countones({sb_en, sr_en, mc_en, ark_en}) <= 1), 1);
      if (sb_en || sr_en || mc_en) chk("busy_in_round", int'(busy), 1);
      if (fin_pending) begin
        chk("final_ark_src", int'(ark_src), 2);
        chk("final_no_mc", int'(mc_en), 0);
        fin_pending = 0;
      end
      if (sr_en && round_idx == 4'd14) fin_pending = 1;
      if (ark_en && ark_src == 2'd0) begin
        chk("init_round_idx", int'(round_idx), 0);
        chk("init_first_ark", n_ark, 0);
      end
      n_sb  += int'(sb_en);
      n_sr  += int'(sr_en);
      n_mc  += int'(mc_en);
      n_ark += int'(ark_en);
      if (done) begin
        chk("done_busy_low", int'(busy), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", cyc - e.t_start, e.lat);
          chk("sb_pulses", n_sb, e.n_sb);
          chk("sr_pulses", n_sr, e.n_sr);
          chk("mc_pulses", n_mc, e.n_mc);
          chk("ark_pulses", n_ark, e.n_ark);
        end
        n_sb = 0; n_sr = 0; n_mc = 0; n_ark = 0;
      end
    end
  end

  // Monitor for the NR=10 instance.
  int n_mc2 = 0;
  always @(negedge clk) begin
    if (rst) begin
      n_mc2 = 0;
    end else begin
      n_mc2 += int'(mc_en2);
      if (done2) begin
        if (exp2_q.size() == 0) begin
          chk("nr10_unexpected_done", 1, 0);
        end else begin
          int t0;
          t0 = exp2_q.pop_front();
          chk("nr10_latency", cyc - t0, 40);
          chk("nr10_mc_pulses", n_mc2, 9);
        end
        n_mc2 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0 || exp2_q.size() != 0) begin
      chk("drain_timeout", exp_q.size() + exp2_q.size(), 0);
      exp_q.delete();
      exp2_q.delete();
    end
    repeat (4) step();
  endtask

  initial begin
    int t;
    int t2;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    chk("idle_busy", int'(busy), 0);
    chk("idle_round_idx", int'(round_idx), 0);

    // Nominal block on both builds, key always ready.
    start = 1'b1; start2 = 1'b1;
    step();
    t = cyc;
    exp_q.push_back('{t, 56, 14, 14, 13, 15});
    exp2_q.push_back(t);
    start = 1'b0; start2 = 1'b0;
    chk("init_busy", int'(busy), 1);
    chk("init_ark_en", int'(ark_en), 1);
    drain();

    // Key stall of three cycles on entering round-5 ARK.
    start = 1'b1;
    step();
    t = cyc;
    exp_q.push_back('{t, 59, 14, 14, 13, 15});
    start = 1'b0;
    wait_until(t + 20);
    chk("stall_entry_round", int'(round_idx), 5);
    chk("stall_entry_src", int'(ark_src), 1);
    key_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_round_hold", int'(round_idx), 5);
      chk("stall_ark_en", int'(ark_en), 0);
      chk("stall_src_hold", int'(ark_src), 1);
      step();
    end
    key_rdy = 1'b1;
    drain();

    // Start held high: back-to-back blocks, done pulses 58 cycles apart.
    start = 1'b1;
    step();
    t = cyc;
    exp_q.push_back('{t, 56, 14, 14, 13, 15});
    exp_q.push_back('{t + 58, 56, 14, 14, 13, 15});
    wait_until(t + 58);
    chk("restart_busy", int'(busy), 1);
    chk("restart_round_idx", int'(round_idx), 0);
    start = 1'b0;
    drain();

    // Reset during round-7 MC aborts the block; the next start completes normally.
    start = 1'b1;
    step();
    t = cyc;
    start = 1'b0;
    wait_until(t + 27);
    chk("abort_at_mc", int'(mc_en), 1);
    chk("abort_round_idx", int'(round_idx), 7);
    rst = 1'b1;
    #1;
    chk("abort_outputs_zero", outs1(), 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    t2 = cyc;
    exp_q.push_back('{t2, 56, 14, 14, 13, 15});
    start = 1'b0;
    drain();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_enc_round_ctrl.md
MOD_ENC_ROUND_CTRL -- requirements
Module: mod_enc_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 14, number of AES rounds (AES-256); the legal range is 2..15.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-high reset; 1 = reset asserted.
REQ-004 SHALL have port start  input  1  request to encrypt the block present on the datapath input.
REQ-005 SHALL have port key_rdy  input  1  round key for round_idx is valid on the key bus.
REQ-006 SHALL have port sb_en  output  1  subBytes register write enable.
REQ-007 SHALL have port sr_en  output  1  shiftRows register write enable.
REQ-008 SHALL have port mc_en  output  1  mixColumns wr_en.
REQ-009 SHALL have port ark_en  output  1  addRoundKey register write enable.
REQ-010 SHALL have port ark_src  output  2  addRoundKey input select: 0 = plaintext, 1 = mixColumns output, 2 = shiftRows output; 3 is unused.
REQ-011 SHALL have port round_idx  output  4  current round number and key-schedule index.
REQ-012 SHALL have port busy  output  1  encryption in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse; ciphertext is valid at the addRoundKey output.

Function
REQ-014 SHALL implement the states IDLE, INIT, SB, SR, MC, ARK, DONE, held in a state register plus a 4-bit round counter.
REQ-015 IDLE: with start=1 at a rising edge, SHALL go to INIT with round=0; otherwise SHALL stay in IDLE.
REQ-016 INIT: ark_src=0; ark_en=key_rdy; with key_rdy=1, SHALL go to SB with round=1; otherwise SHALL hold.
REQ-017 SB: sb_en=1 for one cycle, then SHALL go to SR.
REQ-018 SR: sr_en=1 for one cycle; SHALL go to MC if round<NR, or to ARK if round==NR.
REQ-019 MC: mc_en=1 for one cycle, then SHALL go to ARK.
REQ-020 ARK: ark_src=1 if round<NR, ark_src=2 if round==NR; ark_en=key_rdy.
REQ-021 ARK transitions: with key_rdy=0, SHALL hold state and round; with key_rdy=1 and round<NR, SHALL go to SB and increment round; with key_rdy=1 and round==NR, SHALL go to DONE.
REQ-022 DONE: done=1 for exactly one cycle, then SHALL go to IDLE unconditionally; start is ignored in DONE.
REQ-023 sb_en, sr_en, mc_en, ark_src and round_idx SHALL decode from registered state and round only (Moore outputs).
REQ-024 ark_en SHALL be the only combinational dependency on an input (key_rdy).
REQ-025 At most one of sb_en, sr_en, mc_en, ark_en SHALL be 1 in any cycle.
REQ-026 busy SHALL be 1 in INIT, SB, SR, MC and ARK, and 0 in IDLE and DONE.
REQ-027 round_idx SHALL equal the round counter in all states except IDLE, where it SHALL read 0.
REQ-028 The round counter SHALL never exceed NR and SHALL never wrap.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-030 Latency with key_rdy held at 1: start sampled at edge T gives INIT in cycle T+1 and done=1 in cycle T+(4*NR); for NR=14, done is in cycle T+56.
REQ-031 Each cycle with key_rdy=0 in INIT or ARK SHALL add exactly one cycle of latency.
REQ-032 The final round SHALL skip MC; mc_en SHALL pulse exactly NR-1 times per block.
REQ-033 Per block, sb_en and sr_en SHALL each pulse NR times, and ark_en SHALL pulse NR+1 times.

Reset
REQ-034 resetn=1 SHALL force, immediately and asynchronously, state=IDLE and round=0.
REQ-035 During reset, all enables, busy and done SHALL be 0, and ark_src and round_idx SHALL be 0.
REQ-036 Reset asserted mid-encryption SHALL abort the block with no done pulse.
REQ-037 After resetn deasserts, the first start SHALL be accepted normally.

Verification
REQ-038 Scenario: start pulse at T, key_rdy=1 -> ark_en (src 0) in T+1; done in T+56; 15 ark_en, 14 sb_en, 14 sr_en and 13 mc_en pulses; busy high from T+1 to T+55.
REQ-039 Scenario: key_rdy=0 for 3 cycles on entering round-5 ARK -> state and round_idx=5 held with ark_en=0; done in T+59.
REQ-040 Scenario: final round -> SR (round_idx=14) is followed directly by ARK with ark_src=2 and mc_en=0.
REQ-041 Scenario: start held high throughout -> the second block's INIT occurs in the cycle after IDLE is re-entered, with no overlap and done pulses 58 cycles apart.
REQ-042 Scenario: resetn=1 asserted during round-7 MC -> outputs go to 0 at once; done never pulses; a new start after release completes in 56 cycles.
REQ-043 Scenario: NR=10 build -> done in T+40 with 9 mc_en pulses.
